pwm_comp_gen: RTL
=================

// Module: pwm_comp_gen
// PURPOSE
//   Complementary PWM source for one half-bridge leg; its high/low outputs feed
//   the dead-time (non-overlap) stage that drives the gate FETs.
//   Free-running period counter, double-buffered duty, brake, period-sync pulse.
//   Enforces a minimum pulse width so the 32-cycle dead-time blanking never eats a whole pulse.
// PARAMETERS
//   WIDTH      11  counter/duty width; period = 2^WIDTH clk cycles
//   MIN_PULSE  34  shortest on- or off-time (cycles) allowed on high; shorter requests snap to 0%/100%
// PORTS
//   clk       in   1      system clock
//   rst_n     in   1      reset, asynchronous, active-low
//   en        in   1      run enable; 0 forces IDLE
//   duty      in   WIDTH  requested on-time in clk cycles
//   duty_wr   in   1      1-cycle strobe; captures duty into pending register
//   brake     in   1      1 = force high=low=0 (coast)
//   high      out  1      high-side PWM request (registered)
//   low       out  1      low-side PWM request (registered), complement of high while running
//   synch     out  1      1-cycle pulse at start of each period (registered)
//   duty_ack  out  1      1-cycle pulse: pending duty became active
// BEHAVIOUR
//   Reset: cnt=0, pending=0, pend_vld=0, active=0, state=IDLE; high=low=synch=duty_ack=0.
//   duty_wr: pending<=duty, pend_vld<=1 (any state); later write before transfer overwrites.
//   States:
//     IDLE   cnt held 0; outputs 0. en=1 -> RUN; pending->active if pend_vld (ack next cycle).
//     RUN    cnt+=1 mod 2^WIDTH. brake=1 -> BRAKE. en=0 -> IDLE (cnt<=0).
//     BRAKE  cnt keeps running; high=low=0. en=0 -> IDLE.
//            brake=0 observed on the wrap cycle (cnt==2^WIDTH-1) -> RUN; else stay.
//   Wrap cycle (cnt==2^WIDTH-1, RUN or BRAKE):
//     if pend_vld: active<=pending, pend_vld<=0, duty_ack=1 next cycle;
//     synch=1 next cycle.
//   Simultaneous duty_wr and wrap: written value bypasses to active; duty_ack next cycle.
//   Effective on-time (from active, unsigned WIDTH arithmetic, no overflow):
//     active < MIN_PULSE                -> 0% (high never 1)
//     (2^WIDTH - active) < MIN_PULSE    -> 100% (high always 1)
//     else                              -> high_nxt = (cnt < active)
//   Outputs (RUN): high<=high_nxt, low<=~high_nxt; 1-cycle latency from cnt.
//   Outputs (IDLE/BRAKE): high<=0, low<=0 (low does NOT complement).
//   Invariant: high&&low never 1. high/low change at most twice per period.
//   en falling mid-period: outputs 0 next cycle; active and pending retained.
//   rst_n asserted mid-operation: all state to reset values immediately (async).
// TESTING
//   1. Reset, en=1, duty_wr duty=512 -> ack after first wrap;
//      next period high=1 for 512 cycles, low=1 for 1536; synch every 2048.
//   2. duty=20 and duty=2040 (WIDTH=11, MIN_PULSE=34) -> high constantly 0 / constantly 1
//      over full period; low is the complement.
//   3. Write 300 then 700 in same period -> only 700 takes effect at wrap;
//      one duty_ack; 300 never appears.
//   4. duty_wr coincident with wrap cycle, duty=1000 -> following period uses 1000;
//      duty_ack next cycle.
//   5. brake=1 at cnt=100, released at cnt=900 -> high=low=0 until next wrap,
//      then RUN resumes at cnt=0; synch still pulses during brake.
//   6. en=0 at cnt=400, re-enabled 10 cycles later -> outputs 0 while off;
//      restart at cnt=0 with retained active duty; high&&low never seen (assertion).

Source files
------------

// File: rtl/pwm_comp_gen.sv
// pwm_comp_gen: complementary PWM source for one half-bridge leg, with a double-buffered
// duty, brake/coast, a period-sync pulse and a minimum pulse width that snaps short pulses to 0%/100%.
module pwm_comp_gen #(
    parameter int WIDTH     = 11,
    parameter int MIN_PULSE = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             duty_wr_i,
    input  logic             brake_i,
    output logic             high_o,
    output logic             low_o,
    output logic             synch_o,
    output logic             duty_ack_o
);
    typedef enum logic [1:0] {IDLE, RUN, BRAKE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH:0]   FULL    = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   MINP    = (WIDTH+1)'(MIN_PULSE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, pend_q, pend_d, act_q, act_d;
    logic             pend_vld_q, pend_vld_d;
    logic             high_q, high_d, low_q, low_d, synch_q, synch_d, ack_q, ack_d;
    logic             wrap, start, xfer, high_nxt, run_out;

    assign wrap  = (state_q != IDLE) && en_i && (cnt_q == CNT_MAX);
    assign start = (state_q == IDLE) && en_i;
    // A write landing on a transfer cycle goes straight to active.
    assign xfer  = (wrap || start) && (pend_vld_q || duty_wr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = en_i ? RUN : IDLE;
            RUN:     state_d = !en_i ? IDLE : (brake_i ? BRAKE : RUN);
            BRAKE:   state_d = !en_i ? IDLE : ((wrap && !brake_i) ? RUN : BRAKE);
            default: state_d = IDLE;
        endcase
    end

    // Snapped duty: too-short on- or off-times collapse to a constant level.
    assign high_nxt = ({1'b0, act_q} < MINP)          ? 1'b0 :
                      ((FULL - {1'b0, act_q}) < MINP) ? 1'b1 :
                      (cnt_q < act_q);
    assign run_out  = (state_q == RUN) && en_i && !brake_i;

    always_comb begin
        cnt_d      = (state_q == IDLE || !en_i) ? '0 : cnt_q + 1'b1;
        pend_d     = duty_wr_i ? duty_i : pend_q;
        pend_vld_d = xfer ? 1'b0 : (pend_vld_q || duty_wr_i);
        act_d      = xfer ? (duty_wr_i ? duty_i : pend_q) : act_q;
        high_d     = run_out && high_nxt;
        low_d      = run_out && !high_nxt;
        synch_d    = wrap;
        ack_d      = xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            act_q      <= '0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
            synch_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            act_q      <= act_d;
            high_q     <= high_d;
            low_q      <= low_d;
            synch_q    <= synch_d;
            ack_q      <= ack_d;
        end
    end

    assign high_o     = high_q;
    assign low_o      = low_q;
    assign synch_o    = synch_q;
    assign duty_ack_o = ack_q;
endmodule
